fft_bram_ctrl: RTL

- Access controller (initiator side) for the 64-entry dual-port block RAM in the RFFT datapath.
- Accepts a frame of N real samples on a valid/ready stream and writes each into RAM port A at its bit-reversed address.
- Then reads the frame back as radix-2 butterfly pairs (k, k+N/2) on ports A and B together and presents each pair on a valid/ready output stream.
- Uses the RAM's shared En as its back-pressure stall, so the RAM output registers hold data while the consumer is not ready.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_bram_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the RFFT datapath: frame geometry, controller
// state encoding and the bit-reversal address helper.
package fft_pkg;

  localparam int ADDR_W = 6;
  localparam int N      = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_UNLOAD = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_bram_ctrl.sv
// Initiator-side controller for the dual-port FFT frame RAM: loads a frame in
// bit-reversed order, then streams it out as (k, k+N/2) butterfly pairs.
module fft_bram_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6   // must match fft_pkg::ADDR_W, which sizes bitrev
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [WIDTH-1:0]  In_Data,
  output logic              Ram_En,
  output logic              Ram_We_A,
  output logic [ADDR_W-1:0] Ram_Addr_A,
  output logic [WIDTH-1:0]  Ram_DI_A,
  input  logic [WIDTH-1:0]  Ram_DO_A,
  output logic              Ram_We_B,
  output logic [ADDR_W-1:0] Ram_Addr_B,
  output logic [WIDTH-1:0]  Ram_DI_B,
  input  logic [WIDTH-1:0]  Ram_DO_B,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Out_Data_A,
  output logic [WIDTH-1:0]  Out_Data_B,
  output logic              Out_Last,
  output logic              Busy
);

  import fft_pkg::state_e;
  import fft_pkg::ST_LOAD;
  import fft_pkg::ST_UNLOAD;
  import fft_pkg::ST_DRAIN;
  import fft_pkg::bitrev;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-2:0]   rcnt_q, rcnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                adv;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    In_Ready    = 1'b0;
    Ram_En      = 1'b0;
    Ram_We_A    = 1'b0;
    Ram_Addr_A  = {1'b0, rcnt_q};
    Ram_Addr_B  = {1'b1, rcnt_q};
    adv         = !out_valid_q || Out_Ready;

    unique case (state_q)
      ST_LOAD: begin
        // A sample offered while Rst is high is neither accepted nor written.
        In_Ready   = !Rst;
        Ram_Addr_A = bitrev(wcnt_q);
        if (In_Valid && !Rst) begin
          Ram_En   = 1'b1;
          Ram_We_A = 1'b1;
          wcnt_d   = wcnt_q + 1'b1;
          if (&wcnt_q) state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        // Dropping En while the consumer stalls freezes the RAM output registers.
        Ram_En = adv;
        if (adv) begin
          rcnt_d      = rcnt_q + 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = &rcnt_q;
          if (&rcnt_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && Out_Ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: the RAM array lives outside this block and is deliberately never cleared by Rst.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign Ram_DI_A   = In_Data;
  assign Ram_We_B   = 1'b0;
  assign Ram_DI_B   = '0;
  assign Out_Valid  = out_valid_q;
  assign Out_Last   = out_last_q;
  assign Out_Data_A = Ram_DO_A;
  assign Out_Data_B = Ram_DO_B;
  assign Busy       = (state_q != ST_LOAD);

endmodule
